// File: rtl/sysid_ctrl_pkg.sv
// Shared definitions for the sysid verification controller: FSM state
// encoding, slave word addresses and the data width of the sysid slave.
package sysid_ctrl_pkg;

    localparam int DATA_W = 32;

    // Word addresses of the sysid slave registers
    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    // Controller states, encoded explicitly so the values stay fixed
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_ID  = 3'd1,
        RD_TS  = 3'd2,
        CHECK  = 3'd3,
        FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/sysid_stall_timer.sv
// Stall counter for one Avalon read attempt. Counts cycles while enabled,
// clears on request, and flags the cycle in which the LIMIT-th stalled
// cycle occurs; the counter rewinds to zero by itself after that cycle.
module sysid_stall_timer #(
    parameter int LIMIT = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // Terminal flag: this enabled cycle is the LIMIT-th consecutive one
    assign expired = enable && (count == CW'(LIMIT - 1));

    // Stall count: cleared between attempts and after expiry
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || expired) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sysid_verify_ctrl.sv
// Reads the system ID and timestamp from an Avalon-MM sysid slave, compares
// them against the expected values and reports pass / timeout. Each read is
// guarded by a stall timer; a timed-out read drops avm_read for one cycle
// and restarts the sequence from the ID read, up to MAX_RETRIES times.
module sysid_verify_ctrl
    import sysid_ctrl_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h56B6_4560,
    parameter int          TIMEOUT_CYCLES = 16,
    parameter int          MAX_RETRIES    = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic              avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout_err,
    output logic [DATA_W-1:0] id_value,
    output logic [DATA_W-1:0] ts_value
);

    localparam int RW = $clog2(MAX_RETRIES + 2);

    state_t        state;
    logic          rd_gap;     // one idle cycle between a timeout and the retry
    logic [RW-1:0] retry_cnt;
    logic          reading;
    logic          accept;
    logic          stall;
    logic          timeout;

    assign reading = ((state == RD_ID) || (state == RD_TS)) && !rd_gap;
    assign accept  = reading && !avm_waitrequest;
    assign stall   = reading && avm_waitrequest;

    // Outputs decode straight from state so reset clears them immediately
    assign avm_read    = reading;
    assign avm_address = (state == RD_TS) ? ADDR_TS : ADDR_ID;
    assign busy        = (state != IDLE);
    assign done        = (state == FINISH);

    // Any non-stalled cycle (accept, gap, other state) restarts the count
    sysid_stall_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_stall_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (!stall),
        .enable  (stall),
        .expired (timeout)
    );

    // Sequencer: state, retry bookkeeping and the held result flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rd_gap      <= 1'b0;
            retry_cnt   <= '0;
            pass        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RD_ID;
                        rd_gap      <= 1'b0;
                        retry_cnt   <= '0;
                        pass        <= 1'b0;
                        timeout_err <= 1'b0;
                    end
                end
                RD_ID, RD_TS: begin
                    if (rd_gap) begin
                        rd_gap <= 1'b0;
                    end else if (accept) begin
                        state <= (state == RD_ID) ? RD_TS : CHECK;
                    end else if (timeout) begin
                        if (retry_cnt == RW'(MAX_RETRIES)) begin
                            state       <= FINISH;
                            timeout_err <= 1'b1;
                            pass        <= 1'b0;
                        end else begin
                            state     <= RD_ID;
                            rd_gap    <= 1'b1;
                            retry_cnt <= retry_cnt + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    pass  <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
                    state <= FINISH;
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Capture read data on the accepting cycle of each read
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            id_value <= '0;
            ts_value <= '0;
        end else if (accept) begin
            if (state == RD_ID) begin
                id_value <= avm_readdata;
            end else begin
                ts_value <= avm_readdata;
            end
        end
    end

endmodule
